jk_mod_counter: RTL and testbench

JK_MOD_COUNTER -- requirements
Module: jk_mod_counter

---
 rtl/jk_pkg.sv | 11 +
 rtl/jk_cell.sv | 33 +++
 rtl/jk_mod_counter.sv | 75 +++++++
 tb/tb_jk_mod_counter.sv | 132 +++++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// Shared JK flip-flop command encoding, {J,K}, used by jk_cell and the counter's J/K decode.
package jk_pkg;

  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_RESET  = 2'b01,
    JK_SET    = 2'b10,
    JK_TOGGLE = 2'b11
  } jk_cmd_t;

endpackage

// File: rtl/jk_cell.sv
// Single JK storage cell with synchronous active-high reset to 0; holds only the JK truth table.
module jk_cell (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qbar
);
  import jk_pkg::*;

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    case (jk_cmd_t'({j, k}))
      JK_HOLD:   q_d = q_q;
      JK_RESET:  q_d = 1'b0;
      JK_SET:    q_d = 1'b1;
      JK_TOGGLE: q_d = ~q_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= 1'b0;
    else     q_q <= q_d;
  end

  assign q    = q_q;
  assign qbar = ~q_q;

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-MODULUS counter built from WIDTH JK cells; J/K per bit are decoded here.
// Define JK_CNT_DOWN_EN to enable down counting via the up port (default build counts up only).
module jk_mod_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             up,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             tc
);
  import jk_pkg::*;

  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] next_count;
  logic             q_legal;
  logic             wrap_pt;

`ifndef JK_CNT_DOWN_EN
  logic unused_up;
  assign unused_up = up;
`endif

  // The wanted next count only selects which cells toggle; every bit still updates through its JK cell.
  always_comb begin
    q_legal = ({1'b0, q} < MOD_EXT);
`ifdef JK_CNT_DOWN_EN
    if (!q_legal)        next_count = '0;
    else if (up)         next_count = (q == MAX_VAL) ? '0 : q + WIDTH'(1);
    else                 next_count = (q == '0) ? MAX_VAL : q - WIDTH'(1);
    wrap_pt = up ? (q == MAX_VAL) : (q == '0);
`else
    next_count = (!q_legal || q == MAX_VAL) ? '0 : q + WIDTH'(1);
    wrap_pt    = (q == MAX_VAL);
`endif

    j = '0;
    k = '0;
    if (load) begin
      if ({1'b0, d} < MOD_EXT) begin
        j = d;
        k = ~d;
      end else begin
        j = '0;
        k = '1;
      end
    end else if (en) begin
      j = next_count ^ q;
      k = next_count ^ q;
    end
  end

  assign tc = en && !load && !rst && wrap_pt;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_cell u_cell (
      .clk  (clk),
      .rst  (rst),
      .j    (j[i]),
      .k    (k[i]),
      .q    (q[i]),
      .qbar (qbar[i])
    );
  end

endmodule

// File: tb/tb_jk_mod_counter.sv
// Scoreboard bench for jk_mod_counter (WIDTH=4, MODULUS=10): directed sequences then random stimulus.
module tb_jk_mod_counter;

  localparam int WIDTH   = 4;
  localparam int MODULUS = 10;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             load;
  logic [WIDTH-1:0] d;
  logic             up;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;
  logic             tc;

  typedef struct {
    logic [WIDTH-1:0] q;
    logic             tc;
  } exp_t;

  exp_t sb[$];
  int   model_q = 0;
  int   checks = 0;
  int   failures = 0;

  jk_mod_counter #(.WIDTH(WIDTH), .MODULUS(MODULUS)) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .load (load),
    .d    (d),
    .up   (up),
    .q    (q),
    .qbar (qbar),
    .tc   (tc)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [WIDTH-1:0] actual,
                              input logic [WIDTH-1:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, required, $time);
    end
  endtask

  // Drive one cycle of inputs, record what the DUT must show this cycle, then advance the model.
  task automatic apply_stimulus(input logic r, input logic l, input logic e,
                                input int dv, input logic u);
    exp_t x;
    bit   dir_up;
    @(negedge clk);
    rst  = r;
    load = l;
    en   = e;
    d    = WIDTH'(dv);
    up   = u;
`ifdef JK_CNT_DOWN_EN
    dir_up = u;
`else
    dir_up = 1'b1;
`endif
    #1;
    x.q  = WIDTH'(model_q);
    x.tc = !r && !l && e && (dir_up ? (model_q == MODULUS - 1) : (model_q == 0));
    sb.push_back(x);
    if (r)                  model_q = 0;
    else if (l)             model_q = (dv < MODULUS) ? dv : 0;
    else if (e) begin
      if (model_q >= MODULUS) model_q = 0;
      else if (dir_up)        model_q = (model_q + 1) % MODULUS;
      else                    model_q = (model_q + MODULUS - 1) % MODULUS;
    end
  endtask

  // Monitor: the DUT presents a fresh output every cycle; compare it against the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        exp_t x;
        x = sb.pop_front();
        check_output("q", q, x.q);
        check_output("qbar", qbar, ~x.q);
        check_output("tc", {{(WIDTH-1){1'b0}}, tc}, {{(WIDTH-1){1'b0}}, x.tc});
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; d = '0; up = 1'b1;
    @(posedge clk);
    model_q = 0;

    repeat (2) apply_stimulus(1, 1, 1, 5, 1);
    for (int i = 0; i < 12; i++) apply_stimulus(0, 0, 1, 0, 1);
    apply_stimulus(0, 1, 1, 7, 1);
    apply_stimulus(0, 1, 1, 12, 1);
    apply_stimulus(0, 1, 0, 4, 1);
    repeat (5) apply_stimulus(0, 0, 0, 0, 1);
    apply_stimulus(0, 1, 0, 5, 1);
    apply_stimulus(0, 0, 1, 0, 1);
    apply_stimulus(0, 0, 1, 0, 1);
    apply_stimulus(1, 0, 1, 0, 1);
    repeat (3) apply_stimulus(0, 0, 1, 0, 1);
    apply_stimulus(0, 1, 0, 1, 0);
    repeat (4) apply_stimulus(0, 0, 1, 0, 0);

    for (int i = 0; i < 300; i++) begin
      apply_stimulus(($urandom_range(0, 19) == 0), ($urandom_range(0, 7) == 0),
                     ($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)),
                     1'($urandom_range(0, 1)));
    end
    apply_stimulus(0, 0, 0, 0, 1);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #5;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain: actual=%0d pending required=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
